// File: rtl/ws2812b_pkg.sv
// ----------------------------------------------------------------------------
// ws2812b_pkg
//
// Shared definitions for the WS2812B serial driver:
//   - state_t      : driver FSM states (IDLE, HIGH, LOW, LATCH)
//   - *_DEF        : default bit/latch timing in 20 MHz clock cycles
//   - rgb_to_grb() : reorders a {R,G,B} pixel into WS2812B wire order {G,R,B}
//   - max_u()      : constant-foldable max, used to size the phase counter
// ----------------------------------------------------------------------------
package ws2812b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  // 50 ns per cycle at 20 MHz.
  localparam int unsigned T0H_DEF          = 8;     // 400 ns
  localparam int unsigned T0L_DEF          = 17;    // 850 ns
  localparam int unsigned T1H_DEF          = 16;    // 800 ns
  localparam int unsigned T1L_DEF          = 9;     // 450 ns
  localparam int unsigned RESET_CYCLES_DEF = 1200;  // 60 us latch gap

  localparam int unsigned PIXEL_BITS = 24;

  // The strip expects green first, then red, then blue, each MSB first.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// ----------------------------------------------------------------------------
// ws2812b_bit_timer
//
// Phase timer for the WS2812B driver. A load of N makes `done` assert during
// the N-th cycle after the load edge, so a controller that advances on `done`
// spends exactly N cycles in the phase it just started. Reloading on the same
// edge that `done` is seen chains phases with no gap cycles.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   start a new phase of load_val cycles (load_val >= 1)
//   load_val in   phase length in cycles
//   done     out  high in the last cycle of the running phase
// ----------------------------------------------------------------------------
module ws2812b_bit_timer #(
  parameter int unsigned CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic          active_q;

  // The count holds "cycles remaining after this one", hence the -1 on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= load_val - CW'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Gated by active_q so an expired, un-reloaded timer does not keep firing.
  assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/ws2812b_driver.sv
// ----------------------------------------------------------------------------
// ws2812b_driver
//
// Single-channel WS2812B serialiser, 20 MHz. Accepts one {R,G,B} pixel per
// valid/ready handshake and drives it onto the NRZ line in G,R,B order, MSB
// first. When the pixel was presented with latch=1, the line is then held low
// for RESET_CYCLES so the strip displays the shifted frame.
//
// Handshake: a pixel transfers on a rising clk20 edge where valid && ready.
// ready is high only in IDLE; the source must hold valid/data_in/latch stable
// until that edge, and anything presented while ready=0 is ignored.
//
// Ports:
//   clk20     in   20 MHz clock, rising edge
//   reset     in   asynchronous active-low reset
//   data_in   in   pixel {R[23:16], G[15:8], B[7:0]}
//   valid     in   data_in/latch presented
//   latch     in   emit latch gap after this pixel
//   ready     out  pixel accepted on this cycle's edge if valid
//   dout      out  serial line to strip DIN
//   state_dbg out  current FSM state (observation only)
//
// Build option: define WS2812B_DOUT_INVERT_EN to drive dout as the inverse
// of the line (idles high) for an inverting level shifter. Internal state
// and timing do not change.
// ----------------------------------------------------------------------------
module ws2812b_driver
  import ws2812b_pkg::*;
#(
  parameter int unsigned T0H          = T0H_DEF,
  parameter int unsigned T0L          = T0L_DEF,
  parameter int unsigned T1H          = T1H_DEF,
  parameter int unsigned T1L          = T1L_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic        clk20,
  input  logic        reset,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        dout,
  output state_t      state_dbg
);

  localparam int unsigned BIT_MAX = max_u(T0H + T0L, T1H + T1L);
  localparam int unsigned CNT_MAX = max_u(BIT_MAX, RESET_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  function automatic logic [CW-1:0] high_cycles(input logic b);
    return b ? CW'(T1H) : CW'(T0H);
  endfunction

  function automatic logic [CW-1:0] low_cycles(input logic b);
    return b ? CW'(T1L) : CW'(T0L);
  endfunction

  state_t        state_q, state_n;
  logic [23:0]   shift_q;
  logic [4:0]    idx_q;
  logic          latch_q;
  logic          line_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          do_accept;
  logic          do_shift;
  logic [23:0]   grb_in;

  assign grb_in = rgb_to_grb(data_in);
  assign ready  = (state_q == IDLE);

  ws2812b_bit_timer #(
    .CW (CW)
  ) u_timer (
    .clk      (clk20),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // FSM state register.
  always_ff @(posedge clk20 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and phase-timer control. Every transition that starts a timed
  // phase reloads the timer on the same edge, so phases abut exactly.
  always_comb begin
    state_n   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    do_accept = 1'b0;
    do_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && ready) begin
          do_accept = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = high_cycles(grb_in[23]);
          state_n   = HIGH;
        end
      end
      HIGH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = low_cycles(shift_q[23]);
          state_n  = LOW;
        end
      end
      LOW: begin
        if (tmr_done) begin
          if (idx_q != 5'd0) begin
            // shift_q[22] becomes the MSB on this edge.
            do_shift = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = high_cycles(shift_q[22]);
            state_n  = HIGH;
          end else if (latch_q) begin
            tmr_load = 1'b1;
            tmr_val  = CW'(RESET_CYCLES);
            state_n  = LATCH;
          end else begin
            state_n = IDLE;
          end
        end
      end
      LATCH: begin
        if (tmr_done) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pixel datapath.
  always_ff @(posedge clk20 or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      latch_q <= 1'b0;
    end else if (do_accept) begin
      shift_q <= grb_in;
      idx_q   <= 5'(PIXEL_BITS - 1);
      latch_q <= latch;
    end else if (do_shift) begin
      shift_q <= {shift_q[22:0], 1'b0};
      idx_q   <= idx_q - 5'd1;
    end
  end

  // Registered line level keeps the pin free of decode glitches; it follows
  // the state, so dout rises in the cycle after acceptance.
  always_ff @(posedge clk20 or negedge reset) begin
    if (!reset) begin
      line_q <= 1'b0;
    end else begin
      line_q <= (state_n == HIGH);
    end
  end

`ifdef WS2812B_DOUT_INVERT_EN
  assign dout = ~line_q;
`else
  assign dout = line_q;
`endif

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ws2812b_driver.sv
module tb_ws2812b_driver;
  import ws2812b_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk20   = 1'b0;
  logic        reset   = 1'b0;
  logic [23:0] data_in = '0;
  logic        valid   = 1'b0;
  logic        latch   = 1'b0;
  logic        ready;
  logic        dout;
  state_t      state_dbg;

  always #25 clk20 = ~clk20;

  ws2812b_driver dut (
    .clk20     (clk20),
    .reset     (reset),
    .data_in   (data_in),
    .valid     (valid),
    .latch     (latch),
    .ready     (ready),
    .dout      (dout),
    .state_dbg (state_dbg)
  );

`ifdef WS2812B_DOUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  // Logical line level, independent of pin polarity.
  logic line;
  assign line = dout ^ INV;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge where the first high cycle of a pixel should be
  // visible. Measures each bit's high and low run lengths. The low run of
  // bit 0 ends when the line rises again (b2b) or when ready returns.
  task automatic check_pixel(input string name, input logic [23:0] grb,
                             input logic last_lat, input logic b2b,
                             output int total);
    int hi;
    int lo;
    int exp_lo;
    logic b;
    total = 0;
    for (int i = 23; i >= 0; i--) begin
      b  = grb[i];
      hi = 0;
      while (line === 1'b1 && hi < 1500) begin
        hi++;
        @(negedge clk20);
      end
      lo = 0;
      if (i > 0 || b2b) begin
        while (line === 1'b0 && lo < 1500) begin
          lo++;
          @(negedge clk20);
        end
      end else begin
        while (line === 1'b0 && ready === 1'b0 && lo < 1500) begin
          lo++;
          @(negedge clk20);
        end
      end
      exp_lo = b ? 9 : 17;
      if (i == 0) exp_lo += b2b ? 1 : (last_lat ? 1200 : 0);
      check($sformatf("%s bit%0d high", name, i), hi, b ? 16 : 8);
      check($sformatf("%s bit%0d low", name, i), lo, exp_lo);
      total += hi + lo;
    end
  endtask

  task automatic noise(input logic en);
    if (en) begin
      repeat (400) begin
        @(negedge clk20);
        valid   = 1'($urandom_range(0, 1));
        data_in = 24'($urandom);
        latch   = 1'($urandom_range(0, 1));
      end
      valid = 1'b0;
      latch = 1'b0;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic [23:0] data;
    logic        lat;
    logic        noisy;
    logic [23:0] exp_grb;
    int          exp_total;
  } vec_t;

  vec_t vecs[6];

  task automatic send_and_check(input vec_t v);
    int total;
    @(negedge clk20);
    check({v.name, " ready before"}, ready, 1);
    valid   = 1'b1;
    data_in = v.data;
    latch   = v.lat;
    @(posedge clk20);
    #1;
    valid   = 1'b0;
    data_in = 24'($urandom);
    latch   = 1'b0;
    @(negedge clk20);
    check({v.name, " ready drop"}, ready, 0);
    fork
      check_pixel(v.name, v.exp_grb, v.lat, 1'b0, total);
      noise(v.noisy);
    join
    check({v.name, " total cycles"}, total, v.exp_total);
    check({v.name, " ready back"}, ready, 1);
    check({v.name, " idle state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int total;

    vecs[0] = '{"px00FF00", 24'h00FF00, 1'b0, 1'b0, 24'hFF0000, 600};
    vecs[1] = '{"px000000", 24'h000000, 1'b0, 1'b0, 24'h000000, 600};
    vecs[2] = '{"pxFFFFFF", 24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF, 600};
    vecs[3] = '{"pxA5C33C_noise", 24'hA5C33C, 1'b0, 1'b1, 24'hC3A53C, 600};
    vecs[4] = '{"pxFF0000_latch", 24'hFF0000, 1'b1, 1'b0, 24'h00FF00, 1800};
    vecs[5] = '{"px800000", 24'h800000, 1'b0, 1'b0, 24'h008000, 600};

    // Reset held.
    repeat (3) @(negedge clk20);
    check("rst dout", dout, INV);
    check("rst ready", ready, 1);
    check("rst state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk20);
    check("post rst dout", dout, INV);
    check("post rst ready", ready, 1);

    // Table-driven single pixels.
    for (int i = 0; i < 6; i++) send_and_check(vecs[i]);

    // Back-to-back pixels with valid held.
    @(negedge clk20);
    check("b2b ready before", ready, 1);
    valid   = 1'b1;
    data_in = 24'h0000FF;
    @(posedge clk20);
    #1;
    data_in = 24'h123456;
    @(negedge clk20);
    check_pixel("b2b first", 24'h0000FF, 1'b0, 1'b1, total);
    check("b2b first total", total, 601);
    check("b2b second rise", line, 1);
    valid   = 1'b0;
    data_in = '0;
    check_pixel("b2b second", 24'h341256, 1'b0, 1'b0, total);
    check("b2b second total", total, 600);
    check("b2b ready back", ready, 1);

    // Asynchronous reset in the middle of a pixel.
    @(negedge clk20);
    valid   = 1'b1;
    data_in = 24'hFFFFFF;
    @(posedge clk20);
    #1;
    valid = 1'b0;
    repeat (100) @(negedge clk20);
    check("pre midrst busy", ready, 0);
    #5;
    reset = 1'b0;
    #1;
    check("midrst dout", dout, INV);
    check("midrst ready", ready, 1);
    check("midrst state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk20);
    reset = 1'b1;
    repeat (30) @(negedge clk20);
    check("after midrst line low", line, 0);
    check("after midrst ready", ready, 1);

    // Driver still works after the truncated pixel.
    send_and_check(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
